// File: rtl/mem_stage_lsu.sv
// ============================================================================
//  Module      : mem_stage_lsu
//  Description : Memory-stage load/store unit. Consumes the EX/MEM register
//                fields, runs a req/gnt/rvalid handshake to data memory,
//                positions store lanes and extends load data for MEM/WB.
//                Optional macro LSU_TIMEOUT_EN adds a REQ/WAIT watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_lsu #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  output logic            stall_o,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [31:0]     dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [31:0]     dmem_rdata,
  output logic [XLEN-1:0] load_data,
  output logic            load_valid,
  output logic            err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_is_load;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;

  logic        w_pending;
  logic        w_misalign;
  logic        w_illegal;
  logic        w_err;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_ext;

  assign w_pending = ex_valid & (ex_mem_read | ex_mem_write);

  // Decode width legality and alignment of the access presented in EX/MEM
  always_comb begin
    w_illegal  = (ex_funct3 == 3'b011) || (ex_funct3 == 3'b110) || (ex_funct3 == 3'b111);
    w_misalign = 1'b0;
    if (ex_funct3 == 3'b001 || ex_funct3 == 3'b101) w_misalign = ex_addr[0];
    if (ex_funct3 == 3'b010)                        w_misalign = (ex_addr[1:0] != 2'b00);
  end

  assign w_err = w_illegal | w_misalign;

  // Error accesses never stall: they drop through IDLE so the trap logic sees them
  assign stall_o = w_pending && (r_state != S_DONE) && !((r_state == S_IDLE) && w_err);

  // Byte enables and replicated store data; loads use the same enables
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = ex_wdata[31:0];
    case (ex_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << ex_addr[1:0];
        w_wdata = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {ex_addr[1], 1'b0};
        w_wdata = {2{ex_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = ex_wdata[31:0];
      end
    endcase
  end

  // Lane select and sign/zero extension of the returned load word
  always_comb begin
    case (r_addr_lo)
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ld_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ld_ext = {24'd0, w_byte};
      3'b001:  w_ld_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ld_ext = {16'd0, w_half};
      default: w_ld_ext = dmem_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
  logic [c_tmo_w-1:0] r_tmo;
  logic               w_stuck;
  assign w_stuck = ((r_state == S_REQ) && !dmem_gnt) || ((r_state == S_WAIT) && !dmem_rvalid);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  // Access FSM with registered bus and result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_is_load  <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr_lo  <= 2'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= 4'd0;
      dmem_wdata <= 32'd0;
      load_data  <= '0;
      load_valid <= 1'b0;
      err_o      <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      r_tmo      <= '0;
`endif
    end else begin
      err_o      <= 1'b0;
      load_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pending) begin
            if (w_err) begin
              err_o <= 1'b1;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= ex_mem_write;
              dmem_addr  <= {ex_addr[XLEN-1:2], 2'b00};
              dmem_be    <= w_be;
              dmem_wdata <= w_wdata;
              r_is_load  <= ~ex_mem_write;
              r_funct3   <= ex_funct3;
              r_addr_lo  <= ex_addr[1:0];
              r_state    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (!r_is_load) begin
              r_state <= S_DONE;
            end else if (dmem_rvalid) begin
              load_data  <= w_ld_ext;
              load_valid <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            load_data  <= w_ld_ext;
            load_valid <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef LSU_TIMEOUT_EN
      // Watchdog: counter restarts on entering REQ and aborts a stuck access
      if (r_state == S_IDLE) begin
        r_tmo <= '0;
      end else if (r_state == S_REQ || r_state == S_WAIT) begin
        r_tmo <= r_tmo + 1'b1;
        if (w_stuck && (r_tmo == c_tmo_last)) begin
          dmem_req   <= 1'b0;
          err_o      <= 1'b1;
          load_data  <= '0;
          load_valid <= 1'b0;
          r_state    <= S_DONE;
        end
      end
`endif
    end
  end

endmodule

`default_nettype wire
